// File: rtl/axis_rr_burst_arbiter.sv
// Round-robin burst arbiter: merges NUM_REQ AXI-stream producers into one registered
// write stream for the async fifo. New grants are withheld while the fifo is prog_full.
module axis_rr_burst_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUFF_WORD = 32,
    parameter int MAX_BURST = 8,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           s_valid,
    input  logic [NUM_REQ*BUFF_WORD-1:0] s_data,
    output logic [NUM_REQ-1:0]           s_ready,
    output logic                         m_valid,
    output logic [BUFF_WORD-1:0]         m_data,
    input  logic                         m_ready,
    input  logic                         fifo_prog_full,
    output logic [GW-1:0]                grant_id,
    output logic                         busy,
    output logic [31:0]                  beat_total
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [CW-1:0]        burst_cnt_q, burst_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic [BUFF_WORD-1:0] m_data_q, m_data_d;
    logic [31:0]          beat_total_q, beat_total_d;

    logic                 sel_valid;
    logic [BUFF_WORD-1:0] sel_data;
    logic                 sel_ready;
    logic                 accept;
    logic                 last_beat;
    logic                 found;
    logic [NUM_REQ-1:0]   s_ready_int;
    int                   idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= GW'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            beat_total_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            burst_cnt_q  <= burst_cnt_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            beat_total_q <= beat_total_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        burst_cnt_d  = burst_cnt_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        beat_total_d = beat_total_q;
        s_ready_int  = '0;
        sel_valid    = 1'b0;
        sel_data     = '0;
        accept       = 1'b0;
        found        = 1'b0;
        idx          = 0;
        sel_ready    = ~m_valid_q | m_ready;
        last_beat    = (burst_cnt_q == CW'(MAX_BURST - 1));

        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_q) begin
                sel_valid = s_valid[i];
                sel_data  = s_data[i*BUFF_WORD +: BUFF_WORD];
            end
        end

        // The output register drains in either state; a new accept reloads it.
        if (m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_prog_full && (|s_valid)) begin
                    for (int i = 1; i <= NUM_REQ; i++) begin
                        idx = (int'(grant_q) + i) % NUM_REQ;
                        if (!found && s_valid[idx]) begin
                            found   = 1'b1;
                            grant_d = GW'(idx);
                        end
                    end
                    burst_cnt_d = '0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (GW'(i) == grant_q) begin
                        s_ready_int[i] = sel_ready;
                    end
                end
                accept = sel_valid & sel_ready;
                if (accept) begin
                    m_valid_d    = 1'b1;
                    m_data_d     = sel_data;
                    burst_cnt_d  = burst_cnt_q + CW'(1);
                    beat_total_d = beat_total_q + 32'd1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end else if (sel_ready) begin
                    // Requester gap while we could accept closes the burst.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready    = s_ready_int;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q == XFER);
    assign beat_total = beat_total_q;

endmodule

// File: tb/tb_axis_rr_burst_arbiter.sv
// Self-checking bench for axis_rr_burst_arbiter: random and directed traffic against a
// transaction-level reference model plus an in-order data scoreboard.
module tb_axis_rr_burst_arbiter;

    localparam int NR = 4;
    localparam int BW = 32;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   s_valid = '0;
    logic [NR*BW-1:0] s_data = '0;
    logic [NR-1:0]   s_ready;
    logic            m_valid;
    logic [BW-1:0]   m_data;
    logic            m_ready = 1'b0;
    logic            fifo_prog_full = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic [31:0]     beat_total;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          mdl_busy;
    int          mdl_grant;
    int          mdl_cnt;
    bit          mdl_mvalid;
    logic [31:0] mdl_mdata;
    logic [31:0] mdl_total;
    int          seq [NR];
    logic [31:0] sb [$];

    axis_rr_burst_arbiter #(.NUM_REQ(NR), .BUFF_WORD(BW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .fifo_prog_full(fifo_prog_full), .grant_id(grant_id), .busy(busy),
        .beat_total(beat_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_busy   = 1'b0;
        mdl_grant  = NR - 1;
        mdl_cnt    = 0;
        mdl_mvalid = 1'b0;
        mdl_mdata  = '0;
        mdl_total  = '0;
        sb.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'(NR - 1));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_beat_total", beat_total, 32'd0);
    endtask

    task automatic drive(input int mode);
        case (mode)
            0: begin s_valid = 4'b0001; m_ready = 1'b1; fifo_prog_full = 1'b0; end
            1: begin s_valid = 4'b1111; m_ready = 1'b1; fifo_prog_full = 1'b0; end
            2: begin s_valid = 4'b1111; m_ready = 1'b0; fifo_prog_full = 1'b0; end
            3: begin s_valid = 4'b1111; m_ready = 1'b1; fifo_prog_full = 1'b1; end
            4: begin s_valid = 4'b1011; m_ready = 1'b1; fifo_prog_full = 1'b0; end
            default: begin
                for (int i = 0; i < NR; i++) s_valid[i] = ($urandom % 4) != 0;
                m_ready        = ($urandom % 4) != 0;
                fifo_prog_full = ($urandom % 8) == 0;
            end
        endcase
        for (int i = 0; i < NR; i++) s_data[i*BW +: BW] = {8'(i), 24'(seq[i])};
    endtask

    task automatic model_step();
        logic [NR-1:0] exp_sr;
        logic          sr_g;
        logic          acc;
        logic [31:0]   d;
        exp_sr = '0;
        sr_g   = !mdl_mvalid || m_ready;
        if (mdl_busy) exp_sr[mdl_grant] = sr_g;
        chk("s_ready", 32'(s_ready), 32'(exp_sr));
        chk("m_valid", 32'(m_valid), 32'(mdl_mvalid));
        chk("m_data", m_data, mdl_mdata);
        chk("grant_id", 32'(grant_id), 32'(mdl_grant));
        chk("busy", 32'(busy), 32'(mdl_busy));
        chk("beat_total", beat_total, mdl_total);

        d   = s_data[mdl_grant*BW +: BW];
        acc = mdl_busy && sr_g && s_valid[mdl_grant];
        if (mdl_mvalid && m_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("sb_order", m_data, sb.pop_front());
        end
        if (acc) begin
            sb.push_back(d);
            seq[mdl_grant]++;
            mdl_total++;
            mdl_mvalid = 1'b1;
            mdl_mdata  = d;
        end else if (m_ready) begin
            mdl_mvalid = 1'b0;
        end

        if (mdl_busy) begin
            if (acc) begin
                if (mdl_cnt == MB - 1) mdl_busy = 1'b0;
                mdl_cnt++;
            end else if (sr_g) begin
                mdl_busy = 1'b0;
            end
        end else if (!fifo_prog_full && (s_valid != 0)) begin
            for (int k = 1; k <= NR; k++) begin
                if (!mdl_busy && s_valid[(mdl_grant + k) % NR]) begin
                    mdl_grant = (mdl_grant + k) % NR;
                    mdl_busy  = 1'b1;
                end
            end
            mdl_cnt = 0;
        end
    endtask

    task automatic run_cycles(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            drive(mode);
            #1;
            model_step();
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        #1 rst_n = 1'b1;
        #1;
        model_step();

        run_cycles(60, 0);
        run_cycles(80, 1);
        run_cycles(30, 4);
        run_cycles(5, 1);
        run_cycles(5, 2);
        run_cycles(10, 1);
        run_cycles(5, 3);
        run_cycles(20, 3);
        run_cycles(20, 1);
        run_cycles(2500, 9);

        // Reset in the middle of a burst, right after the third beat.
        run_cycles(3, 1);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            run_cycles(1, 1);
            if (mdl_busy && mdl_cnt == 3) found = 1'b1;
        end
        chk("rst_wait_found", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1);
        #1;
        model_step();

        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            run_cycles(1, 1);
            if (mdl_busy) found = 1'b1;
        end
        chk("post_rst_grant_seen", 32'(found), 32'd1);
        @(negedge clk);
        chk("post_rst_first_grant", 32'(grant_id), 32'd0);
        run_cycles(200, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
